seg_dynamic_scan: RTL and testbench

// Upstream stage of the 74HC595 serial driver. Takes a binary value with decimal-point and sign flags,

---
 rtl/seg_dynamic_scan_pkg.sv | 38 +++
 rtl/seg_dynamic_scan_if.sv | 22 ++
 rtl/seg_dynamic_scan_bcd.sv | 51 +++++
 rtl/seg_dynamic_scan.sv | 116 +++++++++++
 tb/tb_seg_dynamic_scan.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_dynamic_scan_pkg.sv
// Shared constants and helpers for the six-digit multiplexed display.
// Segment codes are common-anode, active-low: bit0=a .. bit6=g, bit7=dp.
package seg_dynamic_scan_pkg;

  localparam int DIGITS = 6;
  localparam logic [19:0] BCD_MAX = 20'd999_999;

  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DP_MASK = 8'h7F;

  localparam logic [9:0][7:0] SEG_DIGIT = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_code(
    input logic [3:0] d
  );
    logic [7:0] r;
    r = SEG_BLANK;
    if (d < 4'd10) r = SEG_DIGIT[d];
    return r;
  endfunction

  // One double-dabble correction step over all BCD digits.
  function automatic logic [23:0] add3(
    input logic [23:0] b
  );
    logic [23:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = (b[4*i+:4] >= 4'd5) ?
        b[4*i+:4] + 4'd3 : b[4*i+:4];
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_dynamic_scan_if.sv
// Value/flag inputs and multiplexed sel/seg outputs of the scan stage.
// The slave side is the display stage, the master side drives the value.
interface seg_dynamic_scan_if;

  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  modport master (
    output data, point, sign, seg_en,
    input  sel, seg
  );

  modport slave (
    input  data, point, sign, seg_en,
    output sel, seg
  );

endinterface

// File: rtl/seg_dynamic_scan_bcd.sv
// Sequential binary-to-BCD converter: one capture cycle, 20 shift steps,
// then a one-cycle done pulse with the full result on bcd.
module bcd_8421_seq
  import seg_dynamic_scan_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [19:0] bin,
  output logic        busy,
  output logic        done,
  output logic [23:0] bcd
);

  logic [19:0] sh;
  logic [23:0] acc;
  logic [23:0] adj;
  logic [4:0]  cnt;

  assign adj = add3(acc);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      bcd  <= '0;
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          sh   <= bin;
          acc  <= '0;
          cnt  <= '0;
          busy <= 1'b1;
        end
      end else begin
        {acc, sh} <= {adj[22:0], sh, 1'b0};
        cnt <= cnt + 5'd1;
        if (cnt == 5'd19) begin
          busy <= 1'b0;
          done <= 1'b1;
          bcd  <= {adj[22:0], sh[19]};
        end
      end
    end
  end

endmodule

// File: rtl/seg_dynamic_scan.sv
// Converts a clamped binary value to BCD and time-multiplexes six digits
// onto registered sel/seg with leading-zero blanking, dp and sign.
module seg_dynamic_scan
  import seg_dynamic_scan_pkg::*;
#(
  parameter int CNT_MAX = 49_999
) (
  input logic sys_clk,
  input logic sys_rst,
  seg_dynamic_scan_if.slave bus
);

  localparam int CW = $clog2(CNT_MAX + 1);

  logic [CW-1:0] scan_cnt;
  logic [2:0]    idx;
  logic          conv_start;
  logic          conv_busy;
  logic          conv_done;
  logic [19:0]   conv_bin;
  logic [23:0]   conv_bcd;
  logic [5:0]    cap_point;
  logic          cap_sign;
  logic [23:0]   disp_bcd;
  logic [5:0]    disp_point;
  logic          disp_sign;
  logic [2:0]    msd;
  logic [3:0]    cur_dig;
  logic [7:0]    cur_seg;
  logic [5:0]    sel_q;
  logic [7:0]    seg_q;

  assign conv_start = ~conv_busy & ~conv_done;
  assign conv_bin = (bus.data > BCD_MAX) ?
    BCD_MAX : bus.data;

  bcd_8421_seq u_bcd (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (conv_start),
    .bin     (conv_bin),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  // Flags ride with the value they were captured with.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cap_point  <= '0;
      cap_sign   <= 1'b0;
      disp_bcd   <= '0;
      disp_point <= '0;
      disp_sign  <= 1'b0;
    end else begin
      if (conv_start) begin
        cap_point <= bus.point;
        cap_sign  <= bus.sign;
      end
      if (conv_done) begin
        disp_bcd   <= conv_bcd;
        disp_point <= cap_point;
        disp_sign  <= cap_sign;
      end
    end
  end

  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_bcd[4*i+:4] != 4'd0 || disp_point[i])
        msd = 3'(i);
    end
  end

  always_comb begin
    cur_dig = disp_bcd[{idx, 2'b00}+:4];
    cur_seg = SEG_BLANK;
    if (idx <= msd) begin
      cur_seg = seg_code(cur_dig) &
        (disp_point[idx] ? SEG_DP_MASK : SEG_BLANK);
    end else if (disp_sign && msd < 3'd5 &&
                 idx == msd + 3'd1) begin
      cur_seg = SEG_MINUS;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CW'(CNT_MAX)) begin
      scan_cnt <= '0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sel_q <= '0;
      seg_q <= SEG_BLANK;
    end else if (bus.seg_en) begin
      sel_q <= 6'b1 << idx;
      seg_q <= cur_seg;
    end else begin
      sel_q <= '0;
      seg_q <= SEG_BLANK;
    end
  end

  assign bus.sel = sel_q;
  assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Bench for seg_dynamic_scan: vector table plus frame scoreboard,
// then scan timing, frame atomicity, seg_en and reset sequences.
module tb_seg_dynamic_scan;

  typedef logic [5:0][7:0] frame_t;

  typedef struct {
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    frame_t      exp;
  } vec_t;

  localparam logic [7:0] SEGT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;

  frame_t sb[$];
  vec_t   vecs[13];
  frame_t f123;

  seg_dynamic_scan_if bus();

  seg_dynamic_scan #(.CNT_MAX(9)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic frame_t fr(
    input logic [7:0] a0, a1, a2, a3, a4, a5
  );
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic frame_t model(
    input logic [19:0] d,
    input logic [5:0] p,
    input logic s
  );
    int v;
    int m;
    int dig[6];
    frame_t f;
    v = (d > 20'd999999) ? 999999 : int'(d);
    for (int i = 0; i < 6; i++) begin
      dig[i] = v % 10;
      v = v / 10;
    end
    m = 0;
    for (int i = 0; i < 6; i++)
      if (dig[i] != 0 || p[i]) m = i;
    for (int i = 0; i < 6; i++) begin
      if (i <= m)
        f[i] = SEGT[dig[i]] & (p[i] ? 8'h7F : 8'hFF);
      else if (s && i == m + 1)
        f[i] = 8'hBF;
      else
        f[i] = 8'hFF;
    end
    return f;
  endfunction

  task automatic check(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic capture_frame(
    output frame_t f,
    output bit ok
  );
    logic [5:0] seen;
    seen = '0;
    f = '1;
    for (int c = 0; c < 200 && seen != 6'h3F; c++) begin
      @(negedge sys_clk);
      for (int i = 0; i < 6; i++) begin
        if (bus.sel == 6'(1 << i)) begin
          f[i] = bus.seg;
          seen[i] = 1'b1;
        end
      end
    end
    ok = (seen == 6'h3F);
  endtask

  task automatic run_frame(input string tag);
    frame_t got;
    frame_t exp;
    bit ok;
    capture_frame(got, ok);
    exp = sb.pop_front();
    check({tag, " timeout"}, 32'(ok), 32'd1);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s d%0d", tag, i),
            32'(got[i]), 32'(exp[i]));
  endtask

  task automatic apply(
    input string tag,
    input logic [19:0] d,
    input logic [5:0] p,
    input logic s,
    input frame_t exp
  );
    bus.data = d;
    bus.point = p;
    bus.sign = s;
    sb.push_back(exp);
    repeat (50) @(negedge sys_clk);
    run_frame(tag);
  endtask

  task automatic sync_slot();
    logic [5:0] prev;
    prev = bus.sel;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      if (bus.sel != prev) break;
    end
  endtask

  function automatic logic [5:0] rot(input logic [5:0] s);
    return (s == 6'h20) ? 6'h01 : s << 1;
  endfunction

  initial begin
    logic [5:0]  cur;
    logic [5:0]  s0;
    logic [19:0] rd;
    logic [5:0]  rp;
    logic        rs;
    int n;
    int bad;
    int first_new;
    int regress;
    bit got_new;

    vecs[0]  = '{20'd123456, 6'b0, 1'b0,
      fr(8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9)};
    vecs[1]  = '{20'd42, 6'b000100, 1'b1,
      fr(8'hA4, 8'h99, 8'h40, 8'hBF, 8'hFF, 8'hFF)};
    vecs[2]  = '{20'd1048575, 6'b0, 1'b0,
      fr(8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90)};
    vecs[3]  = '{20'd1048575, 6'b0, 1'b1,
      fr(8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90)};
    vecs[4]  = '{20'd0, 6'b0, 1'b0,
      fr(8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF)};
    vecs[5]  = '{20'd0, 6'b0, 1'b1,
      fr(8'hC0, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF)};
    vecs[6]  = '{20'd100000, 6'b0, 1'b1,
      fr(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF9)};
    vecs[7]  = '{20'd7, 6'b100000, 1'b1,
      fr(8'hF8, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40)};
    vecs[8]  = '{20'd5, 6'b000001, 1'b1,
      fr(8'h12, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF)};
    vecs[9]  = '{20'd99999, 6'b0, 1'b1,
      fr(8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'hBF)};
    vecs[10] = '{20'd0, 6'b001000, 1'b0,
      fr(8'hC0, 8'hC0, 8'hC0, 8'h40, 8'hFF, 8'hFF)};
    vecs[11] = '{20'd999999, 6'b0, 1'b0,
      fr(8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90)};
    vecs[12] = '{20'd1000000, 6'b0, 1'b0,
      fr(8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90)};
    f123 = vecs[0].exp;

    bus.data = '0;
    bus.point = '0;
    bus.sign = 1'b0;
    bus.seg_en = 1'b1;

    repeat (5) @(negedge sys_clk);
    check("rst sel", 32'(bus.sel), 32'h00);
    check("rst seg", 32'(bus.seg), 32'hFF);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("first sel", 32'(bus.sel), 32'h01);
    check("first seg", 32'(bus.seg), 32'hC0);
    sb.push_back(fr(8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF));
    run_frame("reset frame");

    for (int v = 0; v < 13; v++)
      apply($sformatf("vec%0d", v), vecs[v].data,
            vecs[v].point, vecs[v].sign, vecs[v].exp);

    for (int r = 0; r < 6; r++) begin
      rd = 20'($urandom_range(0, 20'hFFFFF));
      rp = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
      rs = 1'($urandom_range(0, 1));
      apply($sformatf("rnd%0d", r), rd, rp, rs,
            model(rd, rp, rs));
    end

    // Slot length and order with 123456 shown.
    apply("scan setup", 20'd123456, 6'b0, 1'b0, f123);
    sync_slot();
    for (int k = 0; k < 6; k++) begin
      cur = bus.sel;
      for (int i = 0; i < 6; i++)
        if (cur == 6'(1 << i))
          check($sformatf("scan seg%0d", i),
                32'(bus.seg), 32'(f123[i]));
      n = 1;
      for (int c = 0; c < 30; c++) begin
        @(negedge sys_clk);
        if (bus.sel != cur) break;
        n++;
      end
      check($sformatf("slot len %0d", k), n, 10);
      check($sformatf("slot next %0d", k),
            32'(bus.sel), 32'(rot(cur)));
    end

    // Frame atomicity across a value change.
    apply("atom old", 20'd111111, 6'b0, 1'b0,
          fr(8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9));
    bus.data = 20'd222222;
    bad = 0;
    regress = 0;
    got_new = 1'b0;
    first_new = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge sys_clk);
      if (bus.sel != 6'h00) begin
        if (bus.seg == 8'hA4) begin
          if (!got_new) first_new = c;
          got_new = 1'b1;
        end else if (bus.seg == 8'hF9) begin
          if (got_new) regress++;
        end else begin
          bad++;
        end
      end
    end
    check("atom other codes", bad, 0);
    check("atom regress", regress, 0);
    check("atom new seen", 32'(got_new), 32'd1);
    check("atom latency ok",
          32'(first_new >= 0 && first_new <= 22 + 22 + 10),
          32'd1);

    // seg_en dropped mid-slot, restored in the next slot.
    sync_slot();
    repeat (3) @(negedge sys_clk);
    s0 = bus.sel;
    bus.seg_en = 1'b0;
    @(negedge sys_clk);
    check("off sel", 32'(bus.sel), 32'h00);
    check("off seg", 32'(bus.seg), 32'hFF);
    bad = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge sys_clk);
      if (bus.sel != 6'h00 || bus.seg != 8'hFF) bad++;
    end
    check("off held", bad, 0);
    bus.seg_en = 1'b1;
    @(negedge sys_clk);
    check("on sel", 32'(bus.sel), 32'(rot(s0)));
    check("on seg", 32'(bus.seg), 32'hA4);

    // Reset pulse while conversions are running.
    apply("pre rst", 20'd345678, 6'b0, 1'b0,
          fr(8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0));
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst2 sel", 32'(bus.sel), 32'h00);
    check("rst2 seg", 32'(bus.seg), 32'hFF);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst2 first sel", 32'(bus.sel), 32'h01);
    check("rst2 first seg", 32'(bus.seg), 32'hC0);
    n = 0;
    for (int c = 0; c < 20 && bus.sel != 6'h02; c++) begin
      @(negedge sys_clk);
      n++;
    end
    check("rst2 d1 reached", 32'(bus.sel), 32'h02);
    check("rst2 d1 blank", 32'(bus.seg), 32'hFF);
    apply("post rst", 20'd345678, 6'b0, 1'b0,
          fr(8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0));

    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

endmodule
